// File: rtl/fp_sqrt_seq_if.sv
// Request/response bundle for the iterative square-root engine.
//
// Handshake: the master raises start with a stable operand A. The engine
// accepts it only on a rising edge where it is idle (busy=0); requests seen
// while busy=1, including the done cycle, are dropped, so nothing is queued.
// busy stays high from the cycle after acceptance up to and including the
// single done cycle. result and invalid are valid from that done cycle and
// keep their value until the next accepted operand completes.
interface fp_sqrt_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         start;
    logic [W-1:0] A;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         invalid;

    modport master (
        output start, A,
        input  busy, done, result, invalid
    );

    modport slave (
        input  start, A,
        output busy, done, result, invalid
    );
endinterface

// File: rtl/fp_sqrt_seq.sv
// Iterative IEEE-754 square root: restoring digit-by-digit recurrence that
// produces one root bit per clock, followed by a single rounding step.
// Special operands (NaN, zero, infinity, negative, denormal) bypass the
// recurrence and are resolved in the rounding stage.
module fp_sqrt_seq #(
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int BIAS     = 127,
    parameter int ROUND_EN = 1
) (
    input  logic         CLK2,
    input  logic         RST,
    fp_sqrt_seq_if.slave bus,
    output logic [2:0]   state_o
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int N  = MAN_W + 2;           // root bits: hidden + fraction + guard
    localparam int CW = $clog2(N + 1);

    localparam logic [EXP_W:0] BIAS_X = (EXP_W + 1)'(BIAS);
    localparam logic [W-1:0]   QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     a_q, a_d;          // latched operand
    logic [EXP_W-1:0] exp_q, exp_d;      // biased result exponent
    logic [2*N-1:0]   rad_q, rad_d;      // radicand, consumed two bits per step
    logic [N+1:0]     rem_q, rem_d;      // partial remainder
    logic [N-1:0]     q_q, q_d;          // partial root
    logic [CW-1:0]    cnt_q, cnt_d;      // iteration counter
    logic [W-1:0]     result_q, result_d;
    logic             invalid_q, invalid_d;

    // Operand fields and classification
    logic             sign_a;
    logic [EXP_W-1:0] exp_a;
    logic [MAN_W-1:0] frac_a;
    logic             exp_ones, exp_zero, frac_zero;
    logic             is_nan, is_zero, is_den, is_special;
    logic [W-1:0]     spec_res;
    logic             spec_inv;

    // Exponent halving and significand alignment
    logic signed [EXP_W:0] e_s, e_adj, e_half;
    logic [EXP_W:0]        rexp_full;
    logic [N-1:0]          m_n;

    // Recurrence step
    logic [N+1:0] rem_sh, trial;

    // Rounding
    logic               guard, lsb, sticky, rnd_up;
    logic [MAN_W+1:0]   mant_sum;
    logic [EXP_W-1:0]   round_exp;
    logic [MAN_W-1:0]   round_frac;
    logic [W-1:0]       norm_res;
    logic [1:0]         spare_unused;

    // Classify the latched operand and pick the bypass result for specials
    always_comb begin
        sign_a    = a_q[W-1];
        exp_a     = a_q[W-2:MAN_W];
        frac_a    = a_q[MAN_W-1:0];
        exp_ones  = &exp_a;
        exp_zero  = ~|exp_a;
        frac_zero = ~|frac_a;
        is_nan    = exp_ones & ~frac_zero;
        is_zero   = exp_zero & frac_zero;
        is_den    = exp_zero & ~frac_zero;
        // Anything that is not a positive normal skips the recurrence
        is_special = exp_ones | exp_zero | sign_a;

        spec_res = a_q;
        spec_inv = 1'b0;
        if (is_nan) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (is_zero) begin
            spec_res = a_q;
        end else if (is_den) begin
            // Denormals are flushed to a zero of the same sign
            spec_res = {sign_a, {(W-1){1'b0}}};
        end else if (sign_a) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else begin
            spec_res = a_q;              // +inf
        end
    end

    // Unbias, force an even exponent and align the significand to 2.MAN_W
    always_comb begin
        e_s       = {1'b0, exp_a} - BIAS_X;
        e_adj     = e_s - {{EXP_W{1'b0}}, e_s[0]};
        e_half    = e_adj >>> 1;
        rexp_full = e_half + BIAS_X;
        // Odd exponent: the significand is doubled into the upper integer bit
        m_n = e_s[0] ? {1'b1, frac_a, 1'b0} : {2'b01, frac_a};
    end

    // One restoring step: bring down two radicand bits and test 4q+1
    always_comb begin
        rem_sh = {rem_q[N-1:0], rad_q[2*N-1:2*N-2]};
        trial  = {q_q, 2'b01};
    end

    // Round the finished root; a carry out of the mantissa bumps the exponent
    always_comb begin
        guard    = q_q[0];
        lsb      = q_q[1];
        sticky   = |rem_q;
        rnd_up   = (ROUND_EN != 0) && guard && (sticky || lsb);
        mant_sum = {1'b0, q_q[N-1:1]} + {{(MAN_W+1){1'b0}}, rnd_up};
        if (mant_sum[MAN_W+1]) begin
            round_exp  = exp_q + EXP_W'(1);
            round_frac = '0;
        end else begin
            round_exp  = exp_q;
            round_frac = mant_sum[MAN_W-1:0];
        end
        norm_res     = {1'b0, round_exp, round_frac};
        spare_unused = {rexp_full[EXP_W], mant_sum[MAN_W]};
    end

    // Next-state and datapath updates for every register
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        exp_d     = exp_q;
        rad_d     = rad_q;
        rem_d     = rem_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        invalid_d = invalid_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (is_special) begin
                    // Specials are resolved where the normal result is muxed in
                    state_d = S_ROUND;
                end else begin
                    exp_d   = rexp_full[EXP_W-1:0];
                    rad_d   = {m_n, {N{1'b0}}};
                    rem_d   = '0;
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                rad_d = rad_q << 2;
                if (rem_sh >= trial) begin
                    rem_d = rem_sh - trial;
                    q_d   = {q_q[N-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh;
                    q_d   = {q_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (is_special) begin
                    result_d  = spec_res;
                    invalid_d = spec_inv;
                end else begin
                    result_d  = norm_res;
                    invalid_d = 1'b0;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge CLK2 or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            exp_q     <= '0;
            rad_q     <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            exp_q     <= exp_d;
            rad_q     <= rad_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.result  = result_q;
    assign bus.invalid = invalid_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Bench for fp_sqrt_seq: directed test-plan vectors, handshake corner cases,
// mid-operation reset and randomized operands against a real-arithmetic model.
module tb_fp_sqrt_seq;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = EXP_W + MAN_W + 1;
    localparam int LAT_N = 27;
    localparam int LAT_S = 2;

    logic       CLK2;
    logic       RST;
    logic [2:0] state_o;

    fp_sqrt_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_sqrt_seq #(
        .EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(127), .ROUND_EN(1)
    ) dut (
        .CLK2(CLK2),
        .RST(RST),
        .bus(bus),
        .state_o(state_o)
    );

    int total = 0;
    int bad   = 0;
    logic [W:0] exp_q[$];             // {invalid, result} per accepted operand

    // ---------------- clock ----------------
    initial begin
        CLK2 = 1'b0;
        forever #5 CLK2 = ~CLK2;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned r;
        r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Reference: exact integer square root of the scaled significand
    function automatic logic [W:0] sqrt_model(input logic [31:0] a);
        int              ex;
        int              e;
        longint unsigned m, v, r;
        logic [7:0]      rexp;
        ex = int'(a[30:23]);
        if (ex == 255 && a[22:0] != 0) return {1'b1, 32'h7FC00000};
        if (ex == 0 && a[22:0] == 0)   return {1'b0, a};
        if (ex == 0)                   return {1'b0, a[31], 31'h0};
        if (a[31])                     return {1'b1, 32'h7FC00000};
        if (ex == 255)                 return {1'b0, a};
        e = ex - 127;
        m = (64'd1 << 23) | longint'(a[22:0]);
        if ((e & 1) != 0) begin
            m = m << 1;
            e = e - 1;
        end
        v = m << 23;
        r = isqrt(v);
        if (v - r * r > r) r++;               // true root >= r + 0.5
        rexp = 8'(e / 2 + 127);
        if (r >= (64'd1 << 24)) begin
            rexp = rexp + 8'd1;
            r    = 64'd1 << 23;
        end
        return {1'b0, 1'b0, rexp, r[22:0]};
    endfunction

    function automatic bit is_special(input logic [31:0] a);
        return (a[30:23] == 8'hFF) || (a[30:23] == 8'h00) || a[31];
    endfunction

    // ---------------- compare process ----------------
    initial begin
        logic [W:0] held;
        logic [W:0] e;
        logic       prev_done;
        held      = '0;
        prev_done = 1'b0;
        forever begin
            @(negedge CLK2);
            if (!RST) begin
                check("reset_outputs", {bus.busy, bus.done, bus.invalid, bus.result}, '0);
                held      = '0;
                prev_done = 1'b0;
            end else begin
                if (bus.done) begin
                    check("done_single_cycle", prev_done, 1'b0);
                    check("busy_in_done", bus.busy, 1'b1);
                    if (exp_q.size() == 0) begin
                        check("spurious_done", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", bus.result, e[W-1:0]);
                        check("invalid", bus.invalid, e[W]);
                        held = e;
                    end
                end else begin
                    check("held_outputs", {bus.invalid, bus.result}, held);
                end
                prev_done = bus.done;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic [31:0] a, input logic [W:0] e);
        int n;
        n = 0;
        @(negedge CLK2);
        while (bus.busy && n < 100) begin
            @(negedge CLK2);
            n++;
        end
        if (bus.busy) check("idle_timeout", 1'b1, 1'b0);
        bus.A     = a;
        bus.start = 1'b1;
        @(posedge CLK2);
        exp_q.push_back(e);
    endtask

    // Counts edges after acceptance until done is seen (sampled at negedge)
    task automatic wait_done(output int cyc, input bit poke);
        cyc = 0;
        forever begin
            @(posedge CLK2);
            cyc++;
            @(negedge CLK2);
            if (bus.done) break;
            if (poke && cyc == 5) begin
                bus.A     = 32'h41100000;
                bus.start = 1'b1;
            end
            if (poke && cyc == 8) bus.start = 1'b0;
            if (cyc >= 60) begin
                check("done_timeout", 1'b1, 1'b0);
                break;
            end
        end
    endtask

    // mode 0: plain, 1: ignored request while busy, 2: start held high
    task automatic do_op(input logic [31:0] a, input logic [W:0] e, input int lat, input int mode);
        int cyc;
        start_op(a, e);
        if (mode != 2) #1 bus.start = 1'b0;
        wait_done(cyc, mode == 1);
        check("latency", W'(cyc), W'(lat));
        if (mode == 2) begin
            @(posedge CLK2);
            #1 bus.start = 1'b0;
            repeat (35) begin
                @(negedge CLK2);
                check("no_reaccept", bus.busy, 1'b0);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        int          cyc;
        RST       = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;

        // Pin the model with hand-computed values
        check("model_4", sqrt_model(32'h40800000), {1'b0, 32'h40000000});
        check("model_2", sqrt_model(32'h40000000), {1'b0, 32'h3FB504F3});
        check("model_025", sqrt_model(32'h3E800000), {1'b0, 32'h3F000000});
        check("model_9", sqrt_model(32'h41100000), {1'b0, 32'h40400000});
        check("model_neg", sqrt_model(32'hC0800000), {1'b1, 32'h7FC00000});
        check("model_inf", sqrt_model(32'h7F800000), {1'b0, 32'h7F800000});
        check("model_nzero", sqrt_model(32'h80000000), {1'b0, 32'h80000000});
        check("model_nan", sqrt_model(32'h7FA00000), {1'b1, 32'h7FC00000});
        check("model_den", sqrt_model(32'h00000001), {1'b0, 32'h00000000});

        repeat (3) @(negedge CLK2);
        check("reset_state", {bus.busy, bus.done, bus.invalid, bus.result}, '0);
        RST = 1'b1;

        // Directed test-plan vectors
        do_op(32'h40800000, {1'b0, 32'h40000000}, LAT_N, 0);
        do_op(32'h40000000, {1'b0, 32'h3FB504F3}, LAT_N, 0);
        do_op(32'h3E800000, {1'b0, 32'h3F000000}, LAT_N, 0);
        do_op(32'hC0800000, {1'b1, 32'h7FC00000}, LAT_S, 0);
        do_op(32'h7F800000, {1'b0, 32'h7F800000}, LAT_S, 0);
        do_op(32'h80000000, {1'b0, 32'h80000000}, LAT_S, 0);
        do_op(32'h7FA00000, {1'b1, 32'h7FC00000}, LAT_S, 0);
        do_op(32'h00000001, {1'b0, 32'h00000000}, LAT_S, 0);

        // Handshake: start held high, then a request while busy
        do_op(32'h40800000, {1'b0, 32'h40000000}, LAT_N, 2);
        do_op(32'h40000000, {1'b0, 32'h3FB504F3}, LAT_N, 1);

        // Back-to-back: 4.0 then 2.0 with start kept high
        start_op(32'h40800000, {1'b0, 32'h40000000});
        #1 bus.A = 32'h40000000;
        wait_done(cyc, 1'b0);
        check("b2b_lat1", W'(cyc), W'(LAT_N));
        @(posedge CLK2);
        @(negedge CLK2);
        check("b2b_idle", bus.busy, 1'b0);
        @(posedge CLK2);
        exp_q.push_back({1'b0, 32'h3FB504F3});
        #1 bus.start = 1'b0;
        wait_done(cyc, 1'b0);
        check("b2b_lat2", W'(cyc), W'(LAT_N));

        // Reset ten cycles into an operation
        start_op(32'h40800000, {1'b0, 32'h40000000});
        #1 bus.start = 1'b0;
        repeat (10) @(posedge CLK2);
        @(negedge CLK2);
        RST = 1'b0;
        #1;
        check("rst_abort", {bus.busy, bus.done, bus.invalid, bus.result}, '0);
        exp_q.delete();
        repeat (3) @(negedge CLK2);
        RST = 1'b1;
        repeat (35) @(negedge CLK2);
        do_op(32'h41100000, {1'b0, 32'h40400000}, LAT_N, 0);

        // Randomized operands, biased toward positive normals
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                a[31]    = 1'b0;
                a[30:23] = 8'($urandom_range(1, 254));
            end
            do_op(a, sqrt_model(a), is_special(a) ? LAT_S : LAT_N, 0);
        end

        repeat (5) @(negedge CLK2);
        check("queue_drained", W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
